// File: rtl/pc_select_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: opcode and pc_src
// encodings, the 2-bit branch counter type and RV32I immediate extraction.
package pc_select_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        PCSRC_SEQ   = 2'b00,
        PCSRC_PRED  = 2'b01,
        PCSRC_REDIR = 2'b10
    } pc_src_e;

    // 2-bit saturating counter: bit 1 set means "predict taken".
    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_MAX = 2'b11;
    localparam cnt2_t CNT_MIN = 2'b00;

    function automatic cnt2_t cnt_inc(input cnt2_t c);
        return (c == CNT_MAX) ? c : cnt2_t'(c + 2'd1);
    endfunction

    function automatic cnt2_t cnt_dec(input cnt2_t c);
        return (c == CNT_MIN) ? c : cnt2_t'(c - 2'd1);
    endfunction

    // Raw J-type immediate, 21 bits with bit 20 as sign; caller sign-extends.
    function automatic logic [20:0] imm_j(input logic [31:0] ins);
        return {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // Raw B-type immediate, 13 bits with bit 12 as sign; caller sign-extends.
    function automatic logic [12:0] imm_b(input logic [31:0] ins);
        return {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/pc_select_predictor_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port. A read of the
// entry being updated in the same cycle returns the pre-update value.
module bht_2bit
    import pc_select_pkg::*;
#(
    parameter int    DEPTH    = 64,
    parameter cnt2_t CNT_INIT = 2'b01,
    localparam int   IDX      = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx,
    output cnt2_t          rd_cnt,
    input  logic           upd_en,
    input  logic [IDX-1:0] upd_idx,
    input  logic           upd_taken
);

    cnt2_t cnt_q [DEPTH];

    // Read straight from the array, no write-through bypass.
    assign rd_cnt = cnt_q[rd_idx];

    // Reset every counter, otherwise saturate the addressed one toward the outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= upd_taken ? cnt_inc(cnt_q[upd_idx])
                                        : cnt_dec(cnt_q[upd_idx]);
        end
    end

endmodule

// File: rtl/pc_select_predictor.sv
// Fetch-stage next-PC unit. Owns the PC register and picks, each cycle,
// between the sequential PC, a predicted JAL/branch target and an EX redirect.
// Conditional branches are predicted from a 2-bit counter table trained by EX.
module pc_select_predictor
    import pc_select_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               BHT_DEPTH = 64,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [1:0]       CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] instr,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [1:0]      pc_src,
    output logic            if_flush,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    logic            is_jal;
    logic            is_branch;
    logic [20:0]     j_raw;
    logic [12:0]     b_raw;
    logic [XLEN-1:0] j_off;
    logic [XLEN-1:0] b_off;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;
    pc_src_e         src_sel;
    cnt2_t           rd_cnt;
    logic [IDX-1:0]  rd_idx;
    logic [IDX-1:0]  upd_idx;
    logic            upd_en;

    assign opcode    = instr[6:0];
    assign is_jal    = (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BRANCH);

    assign j_raw = imm_j(instr[31:0]);
    assign b_raw = imm_b(instr[31:0]);
    assign j_off = {{(XLEN-21){j_raw[20]}}, j_raw};
    assign b_off = {{(XLEN-13){b_raw[12]}}, b_raw};

    // Word-aligned PC bits index the table; the low two bits are always zero.
    assign rd_idx  = pc[IDX+1:2];
    assign upd_idx = ex_pc[IDX+1:2];
    assign upd_en  = ex_valid & ex_is_branch;

    bht_2bit #(
        .DEPTH    (BHT_DEPTH),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (rd_idx),
        .rd_cnt    (rd_cnt),
        .upd_en    (upd_en),
        .upd_idx   (upd_idx),
        .upd_taken (ex_taken)
    );

    assign seq_pc       = pc + XLEN'(4);
    assign mispredict   = ex_valid & (ex_taken != ex_pred_taken);
    assign redir_target = ex_taken ? ex_target : (ex_pc + XLEN'(4));

    // Prediction for the instruction at pc; JALR is never predicted.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = seq_pc;
        if (is_jal) begin
            pred_taken  = 1'b1;
            pred_target = pc + j_off;
        end else if (is_branch) begin
            pred_taken  = rd_cnt[1];
            pred_target = pc + b_off;
        end
    end

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        src_sel  = PCSRC_SEQ;
        if_flush = 1'b0;
        next_pc  = seq_pc;
        if (mispredict) begin
            src_sel  = PCSRC_REDIR;
            if_flush = 1'b1;
            next_pc  = redir_target;
        end else if (stall) begin
            next_pc  = pc;
        end else if (pred_taken) begin
            src_sel  = PCSRC_PRED;
            next_pc  = pred_target;
        end
    end

    assign pc_src = src_sel;

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Redirect counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF)) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_select_predictor.sv
// Directed bench for pc_select_predictor with RESET_PC = 0x100.
module tb_pc_select_predictor;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ_P16  = 32'h0000_0863;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] instr;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [1:0]  pc_src;
    logic        if_flush;
    logic [31:0] mispredict_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pc_select_predictor #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .RESET_PC  (32'h0000_0100),
        .CNT_INIT  (2'b01)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .instr          (instr),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pc_src         (pc_src),
        .if_flush       (if_flush),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall         = 1'b0;
        instr         = NOP;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b0;
        ex_target     = '0;
    endtask

    // Jump fetch to target through an EX redirect (counts one mispredict).
    task automatic redirect(input logic [31:0] target);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b0;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b1;
        ex_target     = target;
        tick();
        idle();
    endtask

    task automatic train(input logic [31:0] bpc, input logic taken);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = bpc;
        ex_pred_taken = taken;
        ex_taken      = taken;
        ex_target     = bpc + 32'h10;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_pc", pc, 32'h100);
        chk("reset_mcnt", mispredict_cnt, 32'h0);

        reset = 1'b0;
        #1;
        chk("seq_src0", {30'b0, pc_src}, 32'h0);
        chk("seq_pred0", {31'b0, pred_taken}, 32'h0);
        tick();
        chk("seq_pc104", pc, 32'h104);
        tick();
        chk("seq_pc108", pc, 32'h108);
        chk("seq_mcnt", mispredict_cnt, 32'h0);

        // JAL at 0x200 with offset -8
        redirect(32'h200);
        chk("redir_pc200", pc, 32'h200);
        chk("redir_mcnt1", mispredict_cnt, 32'h1);
        instr = JAL_M8;
        #1;
        chk("jal_pred", {31'b0, pred_taken}, 32'h1);
        chk("jal_src", {30'b0, pc_src}, 32'h1);
        chk("jal_flush", {31'b0, if_flush}, 32'h0);
        tick();
        chk("jal_next", pc, 32'h1F8);
        idle();

        // Branch at 0x40 trained taken twice: 01 -> 10 -> 11
        train(32'h40, 1'b1);
        train(32'h40, 1'b1);
        redirect(32'h40);
        chk("mcnt2", mispredict_cnt, 32'h2);
        instr = BEQ_P16;
        #1;
        chk("beq_t_pred", {31'b0, pred_taken}, 32'h1);
        chk("beq_t_src", {30'b0, pc_src}, 32'h1);
        tick();
        chk("beq_t_next", pc, 32'h50);
        idle();

        // Trained not taken twice: 11 -> 10 -> 01
        train(32'h40, 1'b0);
        train(32'h40, 1'b0);
        redirect(32'h40);
        instr = BEQ_P16;
        #1;
        chk("beq_nt_pred", {31'b0, pred_taken}, 32'h0);
        chk("beq_nt_src", {30'b0, pc_src}, 32'h0);
        tick();
        chk("beq_nt_next", pc, 32'h44);

        // Plain stall holds pc even with a JAL in fetch
        instr = JAL_M8;
        stall = 1'b1;
        #1;
        chk("stall_src", {30'b0, pc_src}, 32'h0);
        chk("stall_pred", {31'b0, pred_taken}, 32'h1);
        tick();
        chk("stall_hold", pc, 32'h44);

        // Redirect overrides stall
        instr         = NOP;
        ex_valid      = 1'b1;
        ex_pred_taken = 1'b1;
        ex_taken      = 1'b0;
        ex_pc         = 32'h80;
        ex_target     = 32'h999;
        #1;
        chk("stall_redir_flush", {31'b0, if_flush}, 32'h1);
        chk("stall_redir_src", {30'b0, pc_src}, 32'h2);
        tick();
        chk("stall_redir_pc", pc, 32'h84);
        chk("stall_redir_mcnt", mispredict_cnt, 32'h4);
        idle();

        // Same-index read and update: counter 01 read, 10 written (stalled)
        redirect(32'h40);
        instr         = BEQ_P16;
        stall         = 1'b1;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h40;
        ex_pred_taken = 1'b1;
        ex_taken      = 1'b1;
        ex_target     = 32'h50;
        #1;
        chk("rw_old_pred", {31'b0, pred_taken}, 32'h0);
        tick();
        chk("rw_hold", pc, 32'h40);
        idle();
        instr = BEQ_P16;
        #1;
        chk("rw_new_pred", {31'b0, pred_taken}, 32'h1);
        chk("rw_new_src", {30'b0, pc_src}, 32'h1);
        tick();
        chk("rw_new_next", pc, 32'h50);
        idle();

        // Sequential add wraps
        redirect(32'hFFFF_FFFC);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_post", pc, 32'h0);
        chk("wrap_mcnt", mispredict_cnt, 32'h6);

        // Reset beats a concurrent redirect and training (counter 10 -> would be 11)
        reset         = 1'b1;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h40;
        ex_pred_taken = 1'b0;
        ex_taken      = 1'b1;
        ex_target     = 32'h300;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rst2_pc", pc, 32'h100);
        chk("rst2_mcnt", mispredict_cnt, 32'h0);
        redirect(32'h40);
        instr = BEQ_P16;
        #1;
        chk("rst2_cnt_init", {31'b0, pred_taken}, 32'h0);
        tick();
        chk("rst2_next", pc, 32'h44);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pc_select_predictor.md
# pc_select_predictor

Fetch-stage next-PC unit for the RV32I pipeline. It owns the PC register and selects each cycle between the sequential PC, a predicted JAL/branch target, and an EX-stage redirect. Conditional branches are predicted with a parametrised table of 2-bit saturating counters, trained from EX resolution. It replaces the earlier combinational, JAL-only address select.

## Interface
Parameters:
- XLEN, 32: PC/instruction width.
- BHT_DEPTH, 64: counter entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000: PC value after reset.
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC (hazard unit).
- instr  in  XLEN  instruction at `pc`, valid in the same cycle.
- ex_valid  in  1  EX resolves a control-flow instruction this cycle.
- ex_is_branch  in  1  resolved instruction is a conditional branch.
- ex_pc  in  XLEN  PC of the resolved instruction.
- ex_pred_taken  in  1  prediction carried down the pipe for it.
- ex_taken  in  1  actual outcome; JAL/JALR always 1.
- ex_target  in  XLEN  actual taken target.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  prediction for `instr` (combinational).
- pc_src  out  2  00 sequential, 01 predicted, 10 redirect.
- if_flush  out  1  kill IF/ID contents; high on redirect.
- mispredict_cnt  out  32  saturating count of redirects.

## Operation
- Decode `instr[6:0]`:
  - 1101111 (JAL): always predicted taken. Target = pc + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 1100011 (branch): predicted taken iff bht[pc[IDX+1:2]][1] = 1, with IDX = log2(BHT_DEPTH). Target = pc + sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - All other opcodes, including JALR (1100111): not taken.
- mispredict = ex_valid & (ex_taken != ex_pred_taken).
- Redirect target: ex_taken ? ex_target : ex_pc + 4.
- next_pc priority:
  1. reset: RESET_PC.
  2. mispredict: redirect target, pc_src = 10, if_flush = 1.
  3. stall: pc held, pc_src = 00.
  4. pred_taken: predicted target, pc_src = 01.
  5. Otherwise: pc + 4, pc_src = 00.
- A redirect overrides stall.
- All adds are modulo 2^XLEN and wrap silently.
- BHT training: on ex_valid & ex_is_branch, entry ex_pc[IDX+1:2] saturates up if taken (max 11) and down if not taken (min 00). Training is independent of stall.
- Read/write to the same index in one cycle: the read returns the old counter (no bypass).
- mispredict_cnt increments on each mispredict and holds at 32'hFFFF_FFFF.

## Timing
- Reset values: pc = RESET_PC; every counter = CNT_INIT; mispredict_cnt = 0. pc_src, pred_taken and if_flush follow the reset pc.
- The PC register updates at the edge after selection. A redirect therefore fetches from the new PC one cycle after ex_valid.
- pred_taken, pc_src and if_flush are combinational from pc, instr and the EX inputs. They must settle within one cycle.
- Counter updates and mispredict_cnt are visible the cycle after the training edge.
- Reset asserted mid-operation overrides a redirect and a counter update in the same cycle.

## Structure
- Package pc_select_pkg:
  - opcode constants OP_JAL, OP_BRANCH, OP_JALR.
  - pc_src encodings PCSRC_SEQ, PCSRC_PRED, PCSRC_REDIR.
  - 2-bit counter type with saturating inc/dec functions.
  - J-type and B-type immediate extraction functions.
- One sub-module, bht_2bit:
  - parametrised counter array with one combinational read port and one synchronous update port.
  - synchronous reset to CNT_INIT.

## Test plan
- Reset with RESET_PC = 32'h100, then release with no stall and NOPs. Required: pc = 100, 104, 108; pc_src = 00; mispredict_cnt = 0.
- At pc = 32'h200, instr = JAL with offset -8 (32'hFF9FF06F). Required: pred_taken = 1, pc_src = 01, next pc = 32'h1F8.
- Train the branch at 32'h40 taken twice (01 → 10 → 11), then fetch a BEQ at 32'h40 with offset +16. Required: pred_taken = 1, next pc = 32'h50. Train not taken twice; the next fetch goes to 32'h44.
- ex_valid = 1, ex_pred_taken = 1, ex_taken = 0, ex_pc = 32'h80, with stall = 1. Required: if_flush = 1, pc_src = 10, next pc = 32'h84, mispredict_cnt increments.
- Update and fetch the same index in one cycle. Required: the prediction uses the old counter, and the new value is used on the following cycle.
- Assert reset while a redirect and a training update are active. Required: pc = RESET_PC, all counters = CNT_INIT, mispredict_cnt = 0.
